// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if
//   Bundles the fetch, loader, control/status and instruction-RAM port signals
//   of the instruction memory arbiter.
//   master : arbiter side (drives stall/valid/insn, ld_ready, status, memory controls)
//   slave  : environment side (core fetch stage, loader, RAM)
interface imem_port_arbiter_if #(
   parameter int unsigned INSN_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned MEM_INDEX_WIDTH = 10
);
   // core fetch port
   logic                       fetch_req;
   logic [ADDR_WIDTH-1:0]      fetch_addr;
   logic                       fetch_stall;
   logic                       fetch_valid;
   logic [INSN_WIDTH-1:0]      fetch_insn;
   // loader write port
   logic                       ld_valid;
   logic                       ld_ready;
   logic [ADDR_WIDTH-1:0]      ld_addr;
   logic [INSN_WIDTH-1:0]      ld_data;
   logic                       ld_last;
   // control / status
   logic                       boot_start;
   logic                       hold_req;
   logic                       cpu_hold;
   logic [MEM_INDEX_WIDTH:0]   load_count;
   logic                       ld_range_err;
   // instruction RAM port
   logic                       mem_en;
   logic                       mem_we;
   logic [MEM_INDEX_WIDTH-1:0] mem_index;
   logic [INSN_WIDTH-1:0]      mem_wdata;
   logic [INSN_WIDTH-1:0]      mem_rdata;

   modport master (
      input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_last,
             boot_start, hold_req, mem_rdata,
      output fetch_stall, fetch_valid, fetch_insn, ld_ready, cpu_hold,
             load_count, ld_range_err, mem_en, mem_we, mem_index, mem_wdata
   );

   modport slave (
      output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, ld_last,
             boot_start, hold_req, mem_rdata,
      input  fetch_stall, fetch_valid, fetch_insn, ld_ready, cpu_hold,
             load_count, ld_range_err, mem_en, mem_we, mem_index, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Sequences boot/load of the instruction RAM and arbitrates its single
//   synchronous-read port between core fetches and loader writes (loader wins).
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-low reset
//     bus  - imem_port_arbiter_if.master: fetch port, loader handshake,
//            boot/hold control, load status, RAM control/data
module imem_port_arbiter #(
   parameter int unsigned INSN_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned MEM_OFFSET      = 2,
   parameter int unsigned MEM_INDEX_WIDTH = 10
) (
   input logic                    clk,
   input logic                    rst,
   imem_port_arbiter_if.master    bus
);

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      SWITCH = 2'd1,
      RUN    = 2'd2
   } state_t;

   localparam logic [MEM_INDEX_WIDTH:0] LOAD_MAX = {1'b1, {MEM_INDEX_WIDTH{1'b0}}};
   localparam logic [MEM_INDEX_WIDTH:0] LOAD_ONE = (MEM_INDEX_WIDTH+1)'(1);

   state_t                   state_q, state_d;
   logic                     fetch_valid_q, fetch_valid_d;
   logic [MEM_INDEX_WIDTH:0] load_count_q, load_count_d;
   logic                     ld_range_err_q, ld_range_err_d;

   logic ld_ready;
   logic ld_fire;
   logic fetch_grant;
   logic addr_high_nz;
   logic unused_addr_bits;

   // Only the word-index slice of each address drives the RAM.
   assign unused_addr_bits = ^{bus.fetch_addr, bus.ld_addr};
   assign addr_high_nz     = (bus.ld_addr >> (MEM_OFFSET + MEM_INDEX_WIDTH)) != '0;

   // ld_ready is gated by rst so nothing is accepted or written while in reset.
   assign ld_ready    = rst && (state_q != SWITCH);
   assign ld_fire     = bus.ld_valid && ld_ready;
   assign fetch_grant = rst && (state_q == RUN) && bus.fetch_req && !ld_fire;

   // state register and status flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= HOLD;
         fetch_valid_q  <= 1'b0;
         load_count_q   <= '0;
         ld_range_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         fetch_valid_q  <= fetch_valid_d;
         load_count_q   <= load_count_d;
         ld_range_err_q <= ld_range_err_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HOLD:    if ((ld_fire && bus.ld_last) || bus.boot_start) state_d = SWITCH;
         SWITCH:  state_d = RUN;
         RUN:     if (bus.hold_req) state_d = HOLD;
         default: state_d = HOLD;
      endcase
   end

   // status next values
   always_comb begin
      fetch_valid_d  = fetch_grant;
      ld_range_err_d = ld_range_err_q || (ld_fire && addr_high_nz);
      load_count_d   = load_count_q;
      if ((state_q == RUN) && bus.hold_req) begin
         // A new session starts on return to HOLD; a write in that same
         // cycle is its first word.
         load_count_d = ld_fire ? LOAD_ONE : '0;
      end else if (ld_fire && (load_count_q != LOAD_MAX)) begin
         load_count_d = load_count_q + LOAD_ONE;
      end
   end

   // output logic
   always_comb begin
      bus.cpu_hold    = (state_q != RUN);
      bus.ld_ready    = ld_ready;
      bus.fetch_stall = bus.fetch_req && !fetch_grant;
      bus.mem_en      = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_index   = bus.fetch_addr[MEM_OFFSET +: MEM_INDEX_WIDTH];
      bus.mem_wdata   = bus.ld_data;
      if (ld_fire) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = 1'b1;
         bus.mem_index = bus.ld_addr[MEM_OFFSET +: MEM_INDEX_WIDTH];
      end else if (fetch_grant) begin
         bus.mem_en    = 1'b1;
      end
   end

   assign bus.fetch_valid  = fetch_valid_q;
   assign bus.fetch_insn   = bus.mem_rdata;
   assign bus.load_count   = load_count_q;
   assign bus.ld_range_err = ld_range_err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

   localparam int unsigned IW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned MO = 2;
   localparam int unsigned MW = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [IW-1:0] tb_mem [1024];
   logic [IW-1:0] w [4];

   always #5 clk = ~clk;

   imem_port_arbiter_if #(.INSN_WIDTH(IW), .ADDR_WIDTH(AW), .MEM_INDEX_WIDTH(MW)) bus ();

   imem_port_arbiter #(
      .INSN_WIDTH(IW), .ADDR_WIDTH(AW), .MEM_OFFSET(MO), .MEM_INDEX_WIDTH(MW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // synchronous-read RAM stand-in
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) tb_mem[bus.mem_index] <= bus.mem_wdata;
         else            bus.mem_rdata <= tb_mem[bus.mem_index];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
      bus.ld_data    = '0;
      bus.ld_last    = 1'b0;
      bus.boot_start = 1'b0;
      bus.hold_req   = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) tb_mem[i] = '0;
      bus.mem_rdata = '0;
      for (int i = 0; i < 4; i++) w[i] = 32'hA000_0000 + 32'(i);
      clear_inputs();
      bus.ld_valid = 1'b1;

      // reset values, with a loader request pending
      #12;
      check("rst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      check("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
      check("rst_load_count", 64'(bus.load_count), 64'd0);
      check("rst_range_err", 64'(bus.ld_range_err), 64'd0);
      check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("rst_mem_en", 64'(bus.mem_en), 64'd0);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);

      @(negedge clk);
      rst = 1'b1;
      bus.ld_valid = 1'b0;

      // load four words, ld_last on the fourth
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.ld_valid = 1'b1;
         bus.ld_addr  = 32'(i * 4);
         bus.ld_data  = w[i];
         bus.ld_last  = (i == 3);
         #1;
         check("load_ld_ready", 64'(bus.ld_ready), 64'd1);
         check("load_mem_en", 64'(bus.mem_en), 64'd1);
         check("load_mem_we", 64'(bus.mem_we), 64'd1);
         check("load_mem_index", 64'(bus.mem_index), 64'(i));
         check("load_mem_wdata", 64'(bus.mem_wdata), 64'(w[i]));
         check("load_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      end
      @(negedge clk);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      #1;
      check("switch_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("switch_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      check("switch_mem_en", 64'(bus.mem_en), 64'd0);
      check("load_count_4", 64'(bus.load_count), 64'd4);
      @(negedge clk);
      #1;
      check("run_cpu_hold", 64'(bus.cpu_hold), 64'd0);
      check("run_ld_ready", 64'(bus.ld_ready), 64'd1);

      // back-to-back fetches 0x0, 0x4, 0x8
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = 32'(i * 4);
         #1;
         check("fetch_stall", 64'(bus.fetch_stall), 64'd0);
         check("fetch_mem_en", 64'(bus.mem_en), 64'd1);
         check("fetch_mem_we", 64'(bus.mem_we), 64'd0);
         check("fetch_mem_index", 64'(bus.mem_index), 64'(i));
         if (i > 0) begin
            check("fetch_valid", 64'(bus.fetch_valid), 64'd1);
            check("fetch_insn", 64'(bus.fetch_insn), 64'(w[i-1]));
         end
      end
      @(negedge clk);
      bus.fetch_req = 1'b0;
      #1;
      check("fetch_valid_last", 64'(bus.fetch_valid), 64'd1);
      check("fetch_insn_last", 64'(bus.fetch_insn), 64'(w[2]));

      // loader write collides with fetch of 0x8
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h8;
      bus.ld_valid   = 1'b1;
      bus.ld_addr    = 32'h10;
      bus.ld_data    = 32'hD4;
      #1;
      check("coll_stall", 64'(bus.fetch_stall), 64'd1);
      check("coll_mem_we", 64'(bus.mem_we), 64'd1);
      check("coll_mem_index", 64'(bus.mem_index), 64'd4);
      check("coll_fetch_valid", 64'(bus.fetch_valid), 64'd0);
      @(negedge clk);
      bus.ld_valid = 1'b0;
      #1;
      check("coll_fv_none", 64'(bus.fetch_valid), 64'd0);
      check("coll_stall_off", 64'(bus.fetch_stall), 64'd0);
      check("coll_fetch_en", 64'(bus.mem_en), 64'd1);
      check("coll_fetch_we", 64'(bus.mem_we), 64'd0);
      check("coll_fetch_index", 64'(bus.mem_index), 64'd2);
      check("coll_load_count", 64'(bus.load_count), 64'd5);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      #1;
      check("coll_fv", 64'(bus.fetch_valid), 64'd1);
      check("coll_insn", 64'(bus.fetch_insn), 64'(w[2]));

      // hold_req together with an accepted write
      @(negedge clk);
      bus.hold_req = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 32'h14;
      bus.ld_data  = 32'hD5;
      #1;
      check("hold_mem_we", 64'(bus.mem_we), 64'd1);
      check("hold_mem_index", 64'(bus.mem_index), 64'd5);
      check("hold_cpu_hold_pre", 64'(bus.cpu_hold), 64'd0);
      @(negedge clk);
      bus.hold_req   = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0;
      #1;
      check("hold_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      check("hold_load_count", 64'(bus.load_count), 64'd1);
      check("hold_fetch_stall", 64'(bus.fetch_stall), 64'd1);
      check("hold_mem_en", 64'(bus.mem_en), 64'd0);
      check("tb_mem_5", 64'(tb_mem[5]), 64'h0D5);

      // out-of-range loader address wraps, flag is sticky
      @(negedge clk);
      bus.fetch_req = 1'b0;
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 32'h1004;
      bus.ld_data   = 32'hD6;
      #1;
      check("range_mem_index", 64'(bus.mem_index), 64'd1);
      check("range_mem_we", 64'(bus.mem_we), 64'd1);
      check("range_err_pre", 64'(bus.ld_range_err), 64'd0);
      @(negedge clk);
      bus.ld_valid = 1'b0;
      #1;
      check("range_err_set", 64'(bus.ld_range_err), 64'd1);
      check("range_load_count", 64'(bus.load_count), 64'd2);
      @(negedge clk);
      #1;
      check("range_err_sticky", 64'(bus.ld_range_err), 64'd1);

      // boot_start from HOLD, then read back the wrapped word
      @(negedge clk);
      bus.boot_start = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h4;
      #1;
      check("boot1_mem_en", 64'(bus.mem_en), 64'd0);
      check("boot1_stall", 64'(bus.fetch_stall), 64'd1);
      @(negedge clk);
      bus.boot_start = 1'b0;
      #1;
      check("boot1_sw_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("boot1_sw_mem_en", 64'(bus.mem_en), 64'd0);
      check("boot1_sw_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      check("boot1_sw_stall", 64'(bus.fetch_stall), 64'd1);
      @(negedge clk);
      #1;
      check("boot1_run_cpu_hold", 64'(bus.cpu_hold), 64'd0);
      check("boot1_run_mem_en", 64'(bus.mem_en), 64'd1);
      check("boot1_run_index", 64'(bus.mem_index), 64'd1);
      check("boot1_run_stall", 64'(bus.fetch_stall), 64'd0);

      // mid-load and mid-fetch reset
      @(negedge clk);
      bus.ld_valid   = 1'b1;
      bus.ld_addr    = 32'h8;
      bus.ld_data    = 32'hDEAD;
      bus.fetch_addr = 32'h0;
      #1;
      check("wrap_fv", 64'(bus.fetch_valid), 64'd1);
      check("wrap_insn", 64'(bus.fetch_insn), 64'h0D6);
      #1;
      rst = 1'b0;
      #1;
      check("arst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
      check("arst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      check("arst_load_count", 64'(bus.load_count), 64'd0);
      check("arst_range_err", 64'(bus.ld_range_err), 64'd0);
      check("arst_ld_ready", 64'(bus.ld_ready), 64'd0);
      check("arst_mem_en", 64'(bus.mem_en), 64'd0);
      check("arst_mem_we", 64'(bus.mem_we), 64'd0);
      @(negedge clk);
      check("arst_no_write", 64'(tb_mem[2]), 64'(w[2]));
      rst = 1'b1;
      clear_inputs();

      // boot_start with fetch_req pending: first access only in RUN
      @(negedge clk);
      bus.boot_start = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'hC;
      #1;
      check("boot2_mem_en", 64'(bus.mem_en), 64'd0);
      check("boot2_stall", 64'(bus.fetch_stall), 64'd1);
      check("boot2_cpu_hold", 64'(bus.cpu_hold), 64'd1);
      @(negedge clk);
      bus.boot_start = 1'b0;
      #1;
      check("boot2_sw_mem_en", 64'(bus.mem_en), 64'd0);
      check("boot2_sw_ld_ready", 64'(bus.ld_ready), 64'd0);
      @(negedge clk);
      #1;
      check("boot2_run_mem_en", 64'(bus.mem_en), 64'd1);
      check("boot2_run_mem_we", 64'(bus.mem_we), 64'd0);
      check("boot2_run_index", 64'(bus.mem_index), 64'd3);
      check("boot2_run_stall", 64'(bus.fetch_stall), 64'd0);
      check("boot2_run_cpu_hold", 64'(bus.cpu_hold), 64'd0);
      check("boot2_load_count", 64'(bus.load_count), 64'd0);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      #1;
      check("boot2_fv", 64'(bus.fetch_valid), 64'd1);
      check("boot2_insn", 64'(bus.fetch_insn), 64'(w[3]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequencer and arbiter for the single-port, synchronous-read instruction memory of the single-cycle core. It holds the core in a boot/hold state while a program loader streams instruction words into the memory. It then releases the core and shares the memory port between core fetches and further loader writes; loader writes have fixed priority. The block sits between the fetch stage, the loader (debug/serial front end) and the instruction RAM.

## Interface
- INSN_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, byte-address width on fetch and loader ports
- MEM_OFFSET, 2, byte-offset bits dropped to form the word index
- MEM_INDEX_WIDTH, 10, word-index width; memory depth is 2^MEM_INDEX_WIDTH
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- fetch_req  in  1  core requests an instruction fetch
- fetch_addr  in  ADDR_WIDTH  fetch byte address
- fetch_stall  out  1  fetch_req not granted this cycle
- fetch_valid  out  1  fetch_insn carries the word for the fetch granted last cycle
- fetch_insn  out  INSN_WIDTH  mem_rdata passthrough
- ld_valid, ld_ready  in/out  1  loader write handshake
- ld_addr  in  ADDR_WIDTH  loader byte address
- ld_data  in  INSN_WIDTH  loader write word
- ld_last  in  1  final word of a load image
- boot_start  in  1  release core without loading (memory pre-initialised)
- hold_req  in  1  return core to hold for reload
- cpu_hold  out  1  core must not fetch or commit
- load_count  out  MEM_INDEX_WIDTH+1  words accepted in the current load session
- ld_range_err  out  1  sticky: loader address outside memory
- mem_en, mem_we  out  1  memory enable / write enable
- mem_index  out  MEM_INDEX_WIDTH  memory word index
- mem_wdata  out  INSN_WIDTH  write data
- mem_rdata  in  INSN_WIDTH  read data, valid the cycle after a read enable

## Operation
- FSM states: HOLD (reset state), SWITCH, RUN.
- HOLD: cpu_hold=1, ld_ready=1, fetch ignored (fetch_stall=fetch_req).
  - Write accepted with ld_last → SWITCH.
  - boot_start → SWITCH. If both occur together, the write is accepted and the state goes to SWITCH once.
- SWITCH: one cycle; cpu_hold=1, ld_ready=0, no memory access; → RUN unconditionally.
- RUN: cpu_hold=0, ld_ready=1.
  - A loader handshake (ld_valid&ld_ready) takes the port; fetch_stall=fetch_req.
  - Otherwise fetch_req is granted.
  - hold_req → HOLD; a write accepted in the same cycle still completes.
  - ld_last in RUN has no state effect.
- Write grant: mem_en=1, mem_we=1, mem_index=ld_addr[MEM_OFFSET +: MEM_INDEX_WIDTH], mem_wdata=ld_data.
- Fetch grant: mem_en=1, mem_we=0, mem_index=fetch_addr[MEM_OFFSET +: MEM_INDEX_WIDTH]. Low address bits are ignored.
- No grant: mem_en=0, mem_we=0.
- load_count increments on each accepted write and saturates at 2^MEM_INDEX_WIDTH.
  - Cleared on reset.
  - On the RUN→HOLD transition it is set to 1 if a write was accepted that cycle, otherwise 0.
- ld_range_err is set on any accepted write whose ld_addr bits above MEM_OFFSET+MEM_INDEX_WIDTH are nonzero. The write still goes to the wrapped index. The flag clears only on reset.

## Timing
- All memory controls are combinational from state and inputs, so a write lands on the handshake edge.
- Fetch latency is 1 cycle: fetch_valid is registered, high exactly in the cycle after a fetch grant; fetch_insn=mem_rdata.
- Back-to-back fetches sustain one word per cycle; each loader write inserts exactly one stall.
- Reset values: state HOLD, cpu_hold=1, fetch_valid=0, load_count=0, ld_range_err=0.
- While rst is low, ld_ready, mem_en and mem_we are forced to 0.
- Reset asserted mid-load or mid-fetch aborts at once. A pending fetch_valid is dropped, and no write occurs on the reset edge.

## Test plan
- Reset, then load 4 words to byte addresses 0x0,0x4,0x8,0xC with ld_last on the 4th.
  - 4 writes to indices 0-3 and load_count=4.
  - One SWITCH cycle with ld_ready=0, then RUN with cpu_hold=0.
- RUN, fetch_req held with addresses 0x0,0x4,0x8 → fetch_valid on cycles 2-4 with the words written earlier; fetch_stall=0 throughout.
- RUN, ld_valid asserted alongside fetch_req at 0x8 → write granted, fetch_stall=1 for one cycle, fetch of 0x8 granted the next cycle; fetch_valid follows one cycle after that grant.
- HOLD with boot_start=1 and fetch_req=1 → no memory access in HOLD or SWITCH, first fetch grant in RUN; load_count stays 0.
- RUN, hold_req together with an accepted write → write performed, state HOLD, load_count=1, cpu_hold=1 next cycle.
- Write to ld_addr=0x1004 with MEM_INDEX_WIDTH=10 → write to index 1, ld_range_err=1 and sticky. Asserting rst mid-sequence → all outputs return to their reset values immediately.
